// File: rtl/fmps_test_link_checker_pkg.sv
// Shared definitions for the FMPS test stream: packet field layout, status codes
// and checker FSM encoding. The writer and the checker both import this package.
package fmps_test_link_checker_pkg;

    localparam logic [15:0] HDR_MAGIC_DEFAULT = 16'hB6CF;
    localparam int unsigned MAX_FMPSS         = 32;
    localparam int unsigned IDX_W             = $clog2(MAX_FMPSS);
    localparam logic [15:0] CACA_WORD         = 16'hCACA;
    localparam int unsigned CYC_W             = 8;

    // Header word: {magic[31:16], flag[15], index[14:10], zero[9:0]}
    localparam int unsigned HDR_MAGIC_LSB = 16;
    localparam int unsigned HDR_FLAG_BIT  = 15;
    localparam int unsigned HDR_IDX_LSB   = 10;
    localparam int unsigned HDR_IDX_W     = 5;
    localparam int unsigned HDR_PAD_W     = 10;

    // Data word: {zero[31:29], index[28:24], 16'hCACA[23:8], cycle[7:0]}
    localparam int unsigned DAT_PAD_LSB  = 29;
    localparam int unsigned DAT_IDX_LSB  = 24;
    localparam int unsigned DAT_CACA_LSB = 8;
    localparam int unsigned DAT_CYC_LSB  = 0;

    localparam logic [1:0] ST_OK       = 2'd0;
    localparam logic [1:0] ST_BAD_HDR  = 2'd1;
    localparam logic [1:0] ST_BAD_DATA = 2'd2;
    localparam logic [1:0] ST_FRAMING  = 2'd3;

    typedef enum logic [1:0] {
        StHdr     = 2'd0,
        StData    = 2'd1,
        StDiscard = 2'd2
    } fsm_state_e;

endpackage

// File: rtl/fmps_test_link_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module fmpsSatCounter #(
    parameter int unsigned Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] count_q, count_d;

    // Next count: clear, else increment unless already all-ones
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + Width'(1);
        end
    end

    // Count register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/fmps_test_link_checker.sv
// Receive-side checker for the two-word FMPS test packets (header, data).
// Reports a registered status strobe per packet, tracks per-FA-cycle index bitmap.
module fmps_test_link_checker
    import fmps_test_link_checker_pkg::*;
#(
    parameter logic [15:0] HEADER_MAGIC = HDR_MAGIC_DEFAULT,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                 auroraUserClk,
    input  logic                 auroraUserRst_n,
    input  logic                 auroraFAstrobe,
    input  logic                 clearCounters,
    input  logic [31:0]          FMPS_TEST_AXI_STREAM_RX_tdata,
    input  logic                 FMPS_TEST_AXI_STREAM_RX_tvalid,
    input  logic                 FMPS_TEST_AXI_STREAM_RX_tlast,
    output logic                 FMPS_TEST_AXI_STREAM_RX_tready,
    output logic                 statusStrobe,
    output logic [1:0]           statusCode,
    output logic [IDX_W-1:0]     rxIndex,
    output logic [CYC_W-1:0]     rxCycle,
    output logic [MAX_FMPSS-1:0] seenMap,
    output logic [CNT_WIDTH-1:0] goodCount,
    output logic [CNT_WIDTH-1:0] errCount,
    output logic [1:0]           dbgState
);

    fsm_state_e           state_q, state_d;
    logic                 tready_q;
    logic [IDX_W-1:0]     hdr_idx_q, hdr_idx_d;
    logic [MAX_FMPSS-1:0] work_q, work_d, seen_q, seen_d;
    logic                 ref_valid_q, ref_valid_d;
    logic [CYC_W-1:0]     ref_cyc_q, ref_cyc_d;
    logic                 strobe_q, strobe_d;
    logic [1:0]           code_q, code_d;
    logic [IDX_W-1:0]     rx_idx_q, rx_idx_d;
    logic [CYC_W-1:0]     rx_cyc_q, rx_cyc_d;

    logic [31:0]          beat;
    logic                 accept;
    logic [HDR_IDX_W-1:0] hdr_idx_field;
    logic                 hdr_idx_ok, hdr_good, data_good, cyc_good, ref_live;
    logic [CYC_W-1:0]     beat_cyc;
    logic                 pkt_ok, pkt_err;

    assign beat          = FMPS_TEST_AXI_STREAM_RX_tdata;
    assign accept        = FMPS_TEST_AXI_STREAM_RX_tvalid & tready_q;
    assign hdr_idx_field = beat[HDR_IDX_LSB +: HDR_IDX_W];
    assign beat_cyc      = beat[DAT_CYC_LSB +: CYC_W];

    // Header index field bits above the index width must be zero
    if (HDR_IDX_W > IDX_W) begin : g_idx_pad
        assign hdr_idx_ok = (hdr_idx_field[HDR_IDX_W-1:IDX_W] == '0);
    end else begin : g_idx_full
        assign hdr_idx_ok = 1'b1;
    end

    assign hdr_good = (beat[31:HDR_MAGIC_LSB] == HEADER_MAGIC) && beat[HDR_FLAG_BIT] &&
                      hdr_idx_ok && (beat[HDR_PAD_W-1:0] == '0);

    assign data_good = (beat[31:DAT_PAD_LSB] == '0) &&
                       (beat[DAT_IDX_LSB +: IDX_W] == hdr_idx_q) &&
                       (beat[DAT_CACA_LSB +: 16] == CACA_WORD);

    // An FA strobe in the completing cycle invalidates the old reference first
    assign ref_live = ref_valid_q & ~auroraFAstrobe;
    assign cyc_good = !ref_live || (beat_cyc == ref_cyc_q);

    // Framing FSM next state and per-packet status
    always_comb begin
        state_d   = state_q;
        hdr_idx_d = hdr_idx_q;
        strobe_d  = 1'b0;
        code_d    = ST_OK;
        if (accept) begin
            case (state_q)
                StHdr: begin
                    if (FMPS_TEST_AXI_STREAM_RX_tlast) begin
                        strobe_d = 1'b1;
                        code_d   = ST_FRAMING;
                    end else if (hdr_good) begin
                        state_d   = StData;
                        hdr_idx_d = hdr_idx_field[IDX_W-1:0];
                    end else begin
                        strobe_d = 1'b1;
                        code_d   = ST_BAD_HDR;
                        state_d  = StDiscard;
                    end
                end
                StData: begin
                    strobe_d = 1'b1;
                    if (FMPS_TEST_AXI_STREAM_RX_tlast) begin
                        code_d  = (data_good && cyc_good) ? ST_OK : ST_BAD_DATA;
                        state_d = StHdr;
                    end else begin
                        code_d  = ST_FRAMING;
                        state_d = StDiscard;
                    end
                end
                StDiscard: begin
                    if (FMPS_TEST_AXI_STREAM_RX_tlast) begin
                        state_d = StHdr;
                    end
                end
                default: state_d = StHdr;
            endcase
        end
    end

    assign pkt_ok  = strobe_d && (code_d == ST_OK);
    assign pkt_err = strobe_d && (code_d != ST_OK);

    // Bitmap, cycle reference and last-OK-packet bookkeeping
    always_comb begin
        work_d      = auroraFAstrobe ? '0 : work_q;
        seen_d      = auroraFAstrobe ? work_q : seen_q;
        ref_valid_d = auroraFAstrobe ? 1'b0 : ref_valid_q;
        ref_cyc_d   = ref_cyc_q;
        rx_idx_d    = rx_idx_q;
        rx_cyc_d    = rx_cyc_q;
        if (pkt_ok) begin
            work_d[hdr_idx_q] = 1'b1;
            rx_idx_d          = hdr_idx_q;
            rx_cyc_d          = beat_cyc;
            if (!ref_valid_d) begin
                ref_valid_d = 1'b1;
                ref_cyc_d   = beat_cyc;
            end
        end
    end

    // State registers
    always_ff @(posedge auroraUserClk or negedge auroraUserRst_n) begin
        if (!auroraUserRst_n) begin
            state_q     <= StHdr;
            tready_q    <= 1'b0;
            hdr_idx_q   <= '0;
            work_q      <= '0;
            seen_q      <= '0;
            ref_valid_q <= 1'b0;
            ref_cyc_q   <= '0;
            strobe_q    <= 1'b0;
            code_q      <= ST_OK;
            rx_idx_q    <= '0;
            rx_cyc_q    <= '0;
        end else begin
            state_q     <= state_d;
            tready_q    <= 1'b1;
            hdr_idx_q   <= hdr_idx_d;
            work_q      <= work_d;
            seen_q      <= seen_d;
            ref_valid_q <= ref_valid_d;
            ref_cyc_q   <= ref_cyc_d;
            strobe_q    <= strobe_d;
            code_q      <= code_d;
            rx_idx_q    <= rx_idx_d;
            rx_cyc_q    <= rx_cyc_d;
        end
    end

    fmpsSatCounter #(
        .Width (CNT_WIDTH)
    ) u_good_cnt (
        .clk_i   (auroraUserClk),
        .rst_ni  (auroraUserRst_n),
        .clr_i   (clearCounters),
        .inc_i   (pkt_ok),
        .count_o (goodCount)
    );

    fmpsSatCounter #(
        .Width (CNT_WIDTH)
    ) u_err_cnt (
        .clk_i   (auroraUserClk),
        .rst_ni  (auroraUserRst_n),
        .clr_i   (clearCounters),
        .inc_i   (pkt_err),
        .count_o (errCount)
    );

    assign FMPS_TEST_AXI_STREAM_RX_tready = tready_q;
    assign statusStrobe                   = strobe_q;
    assign statusCode                     = code_q;
    assign rxIndex                        = rx_idx_q;
    assign rxCycle                        = rx_cyc_q;
    assign seenMap                        = seen_q;
    assign dbgState                       = state_q;

endmodule

// File: tb/tb_fmps_test_link_checker.sv
// Self-checking bench: directed packets plus random traffic against a packet-level model.
module tb_fmps_test_link_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fa = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] tdata = '0;
    logic        tvalid = 1'b0;
    logic        tlast = 1'b0;
    logic        tready;
    logic        strobe;
    logic [1:0]  code;
    logic [4:0]  rx_idx;
    logic [7:0]  rx_cyc;
    logic [31:0] seen;
    logic [15:0] good_cnt;
    logic [15:0] err_cnt;
    logic [1:0]  dbg_state;

    int num_tests = 0;
    int num_failed = 0;
    bit chk_en = 1'b1;

    always #5 clk = ~clk;

    fmps_test_link_checker dut (
        .auroraUserClk                  (clk),
        .auroraUserRst_n                (rst_n),
        .auroraFAstrobe                 (fa),
        .clearCounters                  (clr),
        .FMPS_TEST_AXI_STREAM_RX_tdata  (tdata),
        .FMPS_TEST_AXI_STREAM_RX_tvalid (tvalid),
        .FMPS_TEST_AXI_STREAM_RX_tlast  (tlast),
        .FMPS_TEST_AXI_STREAM_RX_tready (tready),
        .statusStrobe                   (strobe),
        .statusCode                     (code),
        .rxIndex                        (rx_idx),
        .rxCycle                        (rx_cyc),
        .seenMap                        (seen),
        .goodCount                      (good_cnt),
        .errCount                       (err_cnt),
        .dbgState                       (dbg_state)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        num_tests++;
        if (got !== exp) begin
            num_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] hdr_word(input logic [4:0] idx);
        return {16'hB6CF, 1'b1, idx, 10'b0};
    endfunction

    function automatic logic [31:0] data_word(input logic [4:0] idx, input logic [7:0] cyc);
        return {3'b0, idx, 16'hCACA, cyc};
    endfunction

    // ---------------- reference model (packet level) ----------------
    logic        m_tready, m_strobe, m_refv, m_drop, m_done;
    logic [1:0]  m_code, m_res;
    logic [4:0]  m_idx, m_pidx;
    logic [7:0]  m_cyc, m_ref, m_pcyc;
    logic [31:0] m_seen, m_work, m_hdr;
    logic [15:0] m_good, m_err;
    logic [31:0] m_pkt[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_tready = 0; m_strobe = 0; m_code = 0; m_idx = 0; m_cyc = 0;
            m_seen = 0; m_work = 0; m_good = 0; m_err = 0; m_refv = 0; m_ref = 0;
            m_drop = 0; m_pkt.delete();
        end else begin
            m_done = 0; m_res = 0; m_pidx = 0; m_pcyc = 0;
            if (tvalid && m_tready) begin
                if (m_drop) begin
                    if (tlast) m_drop = 0;
                end else if (m_pkt.size() == 0) begin
                    if (tlast) begin
                        m_done = 1; m_res = 3;
                    end else if (tdata[31:16] == 16'hB6CF && tdata[15] && tdata[9:0] == 0) begin
                        m_pkt.push_back(tdata);
                    end else begin
                        m_done = 1; m_res = 1; m_drop = 1;
                    end
                end else begin
                    m_hdr = m_pkt.pop_front();
                    m_done = 1;
                    if (!tlast) begin
                        m_res = 3; m_drop = 1;
                    end else begin
                        m_pidx = m_hdr[14:10];
                        m_pcyc = tdata[7:0];
                        if (tdata[31:29] != 0 || tdata[28:24] != m_pidx || tdata[23:8] != 16'hCACA)
                            m_res = 2;
                        else if (m_refv && !fa && m_pcyc != m_ref)
                            m_res = 2;
                        else
                            m_res = 0;
                    end
                end
            end
            if (fa) begin
                m_seen = m_work; m_work = 0; m_refv = 0;
            end
            m_strobe = m_done;
            m_code = m_res;
            if (m_done && m_res == 0) begin
                m_work[m_pidx] = 1'b1;
                if (!m_refv) begin m_refv = 1; m_ref = m_pcyc; end
                m_idx = m_pidx; m_cyc = m_pcyc;
                if (m_good != 16'hFFFF) m_good++;
            end
            if (m_done && m_res != 0 && m_err != 16'hFFFF) m_err++;
            if (clr) begin m_good = 0; m_err = 0; end
            m_tready = 1;
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            check_eq("cyc_tready", 32'(tready), 32'(m_tready));
            check_eq("cyc_strobe", 32'(strobe), 32'(m_strobe));
            if (m_strobe) check_eq("cyc_code", 32'(code), 32'(m_code));
            check_eq("cyc_rxIndex", 32'(rx_idx), 32'(m_idx));
            check_eq("cyc_rxCycle", 32'(rx_cyc), 32'(m_cyc));
            check_eq("cyc_seenMap", seen, m_seen);
            check_eq("cyc_goodCount", 32'(good_cnt), 32'(m_good));
            check_eq("cyc_errCount", 32'(err_cnt), 32'(m_err));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic beat(input logic [31:0] d, input logic l);
        tvalid = 1'b1; tdata = d; tlast = l;
        @(negedge clk);
        tvalid = 1'b0; tlast = 1'b0;
    endtask

    task automatic packet(input logic [4:0] idx, input logic [7:0] cyc);
        beat(hdr_word(idx), 1'b0);
        beat(data_word(idx, cyc), 1'b1);
    endtask

    task automatic fa_pulse();
        fa = 1'b1;
        @(negedge clk);
        fa = 1'b0;
    endtask

    task automatic clr_pulse();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    logic [31:0] rd;
    logic        rl, gen_hdr;
    logic [4:0]  cur_idx;
    int          r;

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check_eq("rst_tready", 32'(tready), 32'd0);
        check_eq("rst_strobe", 32'(strobe), 32'd0);
        check_eq("rst_seenMap", seen, 32'd0);
        check_eq("rst_goodCount", 32'(good_cnt), 32'd0);
        check_eq("rst_dbgState", 32'(dbg_state), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rel_tready", 32'(tready), 32'd1);

        // Good packet
        beat(32'hB6CF8400, 1'b0);
        beat(32'h01CACA05, 1'b1);
        check_eq("ok_strobe", 32'(strobe), 32'd1);
        check_eq("ok_code", 32'(code), 32'd0);
        check_eq("ok_rxIndex", 32'(rx_idx), 32'd1);
        check_eq("ok_rxCycle", 32'(rx_cyc), 32'h05);
        check_eq("ok_goodCount", 32'(good_cnt), 32'd1);

        // Bad header, then two discarded beats
        beat(32'hB6CE8400, 1'b0);
        check_eq("badhdr_strobe", 32'(strobe), 32'd1);
        check_eq("badhdr_code", 32'(code), 32'd1);
        beat(32'h01CACA05, 1'b0);
        check_eq("discard1_strobe", 32'(strobe), 32'd0);
        beat(32'h01CACA05, 1'b1);
        check_eq("discard2_strobe", 32'(strobe), 32'd0);
        check_eq("badhdr_errCount", 32'(err_cnt), 32'd1);
        check_eq("badhdr_state", 32'(dbg_state), 32'd0);

        // Bad data: index mismatch, then corrupted CACA
        beat(hdr_word(5'd3), 1'b0);
        beat(data_word(5'd4, 8'h05), 1'b1);
        check_eq("badidx_code", 32'(code), 32'd2);
        beat(hdr_word(5'd3), 1'b0);
        beat(32'h03CACB05, 1'b1);
        check_eq("badcaca_code", 32'(code), 32'd2);
        check_eq("baddata_strobe", 32'(strobe), 32'd1);

        // All 32 indices in one FA cycle
        fa_pulse();
        clr_pulse();
        for (int i = 0; i < 32; i++) packet(5'(i), 8'h22);
        check_eq("all_goodCount", 32'(good_cnt), 32'd32);
        fa_pulse();
        check_eq("all_seenMap", seen, 32'hFFFFFFFF);
        fa_pulse();
        check_eq("empty_seenMap", seen, 32'd0);

        // Framing errors
        beat(hdr_word(5'd7), 1'b1);
        check_eq("single_code", 32'(code), 32'd3);
        beat(hdr_word(5'd7), 1'b0);
        beat(data_word(5'd7, 8'h22), 1'b0);
        check_eq("nolast_strobe", 32'(strobe), 32'd1);
        check_eq("nolast_code", 32'(code), 32'd3);
        check_eq("nolast_state", 32'(dbg_state), 32'd2);
        beat(32'h12345678, 1'b0);
        check_eq("drop_strobe", 32'(strobe), 32'd0);
        beat(32'h9ABCDEF0, 1'b1);
        check_eq("drop_end_strobe", 32'(strobe), 32'd0);
        check_eq("drop_end_state", 32'(dbg_state), 32'd0);

        // Cycle reference: mismatch, and FA strobe on the completing beat
        fa_pulse();
        packet(5'd2, 8'h11);
        check_eq("ref_first_code", 32'(code), 32'd0);
        packet(5'd3, 8'h12);
        check_eq("ref_mismatch_code", 32'(code), 32'd2);
        beat(hdr_word(5'd4), 1'b0);
        fa = 1'b1;
        beat(data_word(5'd4, 8'h12), 1'b1);
        fa = 1'b0;
        check_eq("fa_same_code", 32'(code), 32'd0);
        check_eq("fa_same_seen", seen, 32'h00000004);
        packet(5'd6, 8'h12);
        check_eq("fa_newref_code", 32'(code), 32'd0);
        fa_pulse();
        check_eq("fa_newmap_seen", seen, 32'h00000050);

        // Clear coinciding with a good packet
        beat(hdr_word(5'd9), 1'b0);
        clr = 1'b1;
        beat(data_word(5'd9, 8'h33), 1'b1);
        clr = 1'b0;
        check_eq("clr_strobe", 32'(strobe), 32'd1);
        check_eq("clr_goodCount", 32'(good_cnt), 32'd0);

        // Random traffic
        gen_hdr = 1'b1;
        cur_idx = '0;
        repeat (3000) begin
            fa  = ($urandom_range(0, 49) == 0);
            clr = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 3) != 0) begin
                if (gen_hdr) begin
                    cur_idx = 5'($urandom_range(0, 31));
                    rd = hdr_word(cur_idx);
                    rl = 1'b0;
                end else begin
                    rd = data_word(cur_idx, ($urandom_range(0, 7) == 0) ? 8'h5A : 8'hA5);
                    rl = 1'b1;
                end
                r = int'($urandom_range(0, 19));
                if (r == 0) rd = rd ^ (32'h1 << $urandom_range(0, 31));
                else if (r == 1) rl = ~rl;
                gen_hdr = ~gen_hdr;
                tvalid = 1'b1; tdata = rd; tlast = rl;
            end else begin
                tvalid = 1'b0;
            end
            @(negedge clk);
        end
        tvalid = 1'b0; fa = 1'b0; clr = 1'b0; tlast = 1'b0;
        repeat (2) @(negedge clk);

        // Error counter saturation via back-to-back single-beat packets
        clr_pulse();
        chk_en = 1'b0;
        repeat (65540) beat(32'h0, 1'b1);
        check_eq("sat_code", 32'(code), 32'd3);
        check_eq("sat_errCount", 32'(err_cnt), 32'h0000FFFF);
        chk_en = 1'b1;
        @(negedge clk);

        // Reset in the middle of a packet
        beat(hdr_word(5'd5), 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check_eq("midrst_strobe", 32'(strobe), 32'd0);
        check_eq("midrst_tready", 32'(tready), 32'd0);
        check_eq("midrst_state", 32'(dbg_state), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("midrst_rel_tready", 32'(tready), 32'd1);
        packet(5'd6, 8'h44);
        check_eq("midrst_pkt_strobe", 32'(strobe), 32'd1);
        check_eq("midrst_pkt_code", 32'(code), 32'd0);
        check_eq("midrst_pkt_rxIndex", 32'(rx_idx), 32'd6);
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", num_tests, num_failed);
        $finish;
    end

endmodule
